// File: rtl/i2c_master_byte.sv
// I2C single-byte master: START, 7-bit address + R/W, one data byte, STOP.
// Bus lines are open-drain: sclo/sdao are tied low and scloe/sdaoe pull the
// line down when set.  Each bit is four quarter periods of CLK_DIV clocks;
// a slave may stretch SCL, which freezes the quarter timer at the end of Q1.
`timescale 1ns/1ps

module i2c_master_byte #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       nack,
    output logic [7:0] rdata,
    input  logic       scli,
    input  logic       sdai,
    output logic       sclo,
    output logic       sdao,
    output logic       scloe,
    output logic       sdaoe
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_ADDR  = 3'd2;
    localparam logic [2:0] ST_AACK  = 3'd3;
    localparam logic [2:0] ST_DATA  = 3'd4;
    localparam logic [2:0] ST_DACK  = 3'd5;
    localparam logic [2:0] ST_STOP  = 3'd6;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [2:0] state_q, state_d;
    logic [1:0] qtr_q, qtr_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] bitCnt_q, bitCnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] wbyte_q, wbyte_d;
    logic       rw_q, rw_d;
    logic       ackBit_q, ackBit_d;
    logic       nack_q, nack_d;
    logic       done_q, done_d;
    logic [7:0] rdata_q, rdata_d;
    logic       scloe_q, scloe_d;
    logic       sdaoe_q, sdaoe_d;

    logic isBusy;
    logic tick;
    logic hold;
    logic advance;

    // Pull-down enables for a given phase: returns {scl, sda}, 1 = drive low.
    // Data and ACK bits keep SCL low in Q0 and Q3 and release it in Q1/Q2.
    function automatic logic [1:0] lineDrive(input logic [2:0] st,
                                             input logic [1:0] q,
                                             input logic       bitVal,
                                             input logic       rdMode);
        logic sclLow;
        logic sdaLow;
        sclLow = 1'b0;
        sdaLow = 1'b0;
        case (st)
            ST_START: begin
                sclLow = (q == 2'd3);
                sdaLow = (q == 2'd2) || (q == 2'd3);
            end
            ST_ADDR: begin
                sclLow = (q == 2'd0) || (q == 2'd3);
                sdaLow = ~bitVal;
            end
            ST_DATA: begin
                sclLow = (q == 2'd0) || (q == 2'd3);
                sdaLow = rdMode ? 1'b0 : ~bitVal;
            end
            ST_AACK, ST_DACK: begin
                sclLow = (q == 2'd0) || (q == 2'd3);
                sdaLow = 1'b0;
            end
            ST_STOP: begin
                sclLow = (q == 2'd0);
                sdaLow = (q != 2'd3);
            end
            default: begin
                sclLow = 1'b0;
                sdaLow = 1'b0;
            end
        endcase
        return {sclLow, sdaLow};
    endfunction

    assign isBusy  = (state_q != ST_IDLE);
    assign tick    = (cnt_q == DIV_LAST);
    assign hold    = (qtr_q == 2'd1) && !scli;
    assign advance = isBusy && tick && !hold;

    // Quarter timer: counts while busy, freezes at the end of Q1 while SCL is held low.
    always_comb begin
        cnt_d = cnt_q;
        if (!isBusy) begin
            cnt_d = 8'd0;
        end else if (!tick) begin
            cnt_d = cnt_q + 8'd1;
        end else if (!hold) begin
            cnt_d = 8'd0;
        end
    end

    // Transaction sequencing: phase stepping, shifting, ACK evaluation and result capture.
    always_comb begin
        state_d  = state_q;
        qtr_d    = qtr_q;
        bitCnt_d = bitCnt_q;
        shift_d  = shift_q;
        wbyte_d  = wbyte_q;
        rw_d     = rw_q;
        ackBit_d = ackBit_q;
        nack_d   = nack_q;
        done_d   = 1'b0;
        rdata_d  = rdata_q;

        if (state_q == ST_IDLE) begin
            if (start) begin
                state_d  = ST_START;
                qtr_d    = 2'd0;
                bitCnt_d = 3'd0;
                shift_d  = {addr, rw};
                wbyte_d  = wdata;
                rw_d     = rw;
                nack_d   = 1'b0;
            end
        end else if (advance) begin
            qtr_d = qtr_q + 2'd1;
            case (state_q)
                ST_START: begin
                    if (qtr_q == 2'd3) begin
                        state_d  = ST_ADDR;
                        bitCnt_d = 3'd0;
                    end
                end
                ST_ADDR: begin
                    if (qtr_q == 2'd3) begin
                        shift_d = {shift_q[6:0], 1'b0};
                        if (bitCnt_q == 3'd7) begin
                            state_d = ST_AACK;
                        end else begin
                            bitCnt_d = bitCnt_q + 3'd1;
                        end
                    end
                end
                ST_AACK: begin
                    if (qtr_q == 2'd2) begin
                        ackBit_d = sdai;
                    end
                    if (qtr_q == 2'd3) begin
                        if (ackBit_q) begin
                            nack_d  = 1'b1;
                            state_d = ST_STOP;
                        end else begin
                            state_d  = ST_DATA;
                            bitCnt_d = 3'd0;
                            shift_d  = rw_q ? 8'h00 : wbyte_q;
                        end
                    end
                end
                ST_DATA: begin
                    if ((qtr_q == 2'd2) && rw_q) begin
                        shift_d = {shift_q[6:0], sdai};
                    end
                    if (qtr_q == 2'd3) begin
                        if (!rw_q) begin
                            shift_d = {shift_q[6:0], 1'b0};
                        end
                        if (bitCnt_q == 3'd7) begin
                            state_d = ST_DACK;
                        end else begin
                            bitCnt_d = bitCnt_q + 3'd1;
                        end
                    end
                end
                ST_DACK: begin
                    if (qtr_q == 2'd2) begin
                        ackBit_d = sdai;
                    end
                    if (qtr_q == 2'd3) begin
                        if (!rw_q && ackBit_q) begin
                            nack_d = 1'b1;
                        end
                        state_d = ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (qtr_q == 2'd3) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        if (rw_q && !nack_q) begin
                            rdata_d = shift_q;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Line enables are registered from the upcoming phase so the pins never glitch.
    always_comb begin
        {scloe_d, sdaoe_d} = lineDrive(state_d, qtr_d, shift_d[7], rw_d);
    end

    // State registers; reset simply releases the bus without issuing a STOP.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            qtr_q    <= 2'd0;
            cnt_q    <= 8'd0;
            bitCnt_q <= 3'd0;
            shift_q  <= 8'h00;
            wbyte_q  <= 8'h00;
            rw_q     <= 1'b0;
            ackBit_q <= 1'b0;
            nack_q   <= 1'b0;
            done_q   <= 1'b0;
            rdata_q  <= 8'h00;
            scloe_q  <= 1'b0;
            sdaoe_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            qtr_q    <= qtr_d;
            cnt_q    <= cnt_d;
            bitCnt_q <= bitCnt_d;
            shift_q  <= shift_d;
            wbyte_q  <= wbyte_d;
            rw_q     <= rw_d;
            ackBit_q <= ackBit_d;
            nack_q   <= nack_d;
            done_q   <= done_d;
            rdata_q  <= rdata_d;
            scloe_q  <= scloe_d;
            sdaoe_q  <= sdaoe_d;
        end
    end

    assign busy  = isBusy;
    assign done  = done_q;
    assign nack  = nack_q;
    assign rdata = rdata_q;
    assign sclo  = 1'b0;
    assign sdao  = 1'b0;
    assign scloe = scloe_q;
    assign sdaoe = sdaoe_q;

endmodule

// File: doc/i2c_master_byte.md
I2C_MASTER_BYTE -- requirements
Module: i2c_master_byte

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning clk cycles per quarter SCL bit period (legal range 1..255).
REQ-002 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port resetn  input  1  synchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request one transaction; sampled only while busy=0.
REQ-005 SHALL have port rw  input  1  1=read, 0=write; captured with start.
REQ-006 SHALL have port addr  input  7  target slave address; captured with start.
REQ-007 SHALL have port wdata  input  8  write byte; captured with start.
REQ-008 SHALL have port busy  output  1  high from the cycle after an accepted start until done.
REQ-009 SHALL have port done  output  1  one-cycle pulse at transaction end.
REQ-010 SHALL have port nack  output  1  valid with done; 1 = address or write-data not acknowledged.
REQ-011 SHALL have port rdata  output  8  read byte, updated at done of a successful read.
REQ-012 SHALL have ports scli, sdai  input  1 each  sampled bus levels.
REQ-013 SHALL have ports sclo, sdao  output  1 each  constant 0 (open-drain low value).
REQ-014 SHALL have ports scloe, sdaoe  output  1 each  1 = pull the line low, 0 = release.

Function
REQ-015 SHALL use a quarter-tick counter: one tick every CLK_DIV clk cycles while busy; each bit = 4 quarters Q0..Q3.
REQ-016 SHALL implement states IDLE, START, ADDR, AACK, DATA, DACK, STOP; IDLE -> START on start while busy=0.
REQ-017 START: Q0 release both lines; Q1 SCL high; Q2 sdaoe=1; Q3 scloe=1; then ADDR.
REQ-018 Data bits (ADDR, DATA): Q0 set sdaoe = ~bit with SCL low; Q1 release SCL; Q2 sample sdai with SCL high; Q3 scloe=1.
REQ-019 ADDR SHALL shift out {addr, rw}, MSB first, 8 bits; then AACK.
REQ-020 AACK/DACK bit SHALL use the same 4-quarter timing; for ACK samples the master releases SDA.
REQ-021 AACK sampled 1 -> nack=1, go to STOP skipping DATA; sampled 0 -> DATA.
REQ-022 DATA write: shift out wdata MSB first; DACK samples slave ACK, sampled 1 -> nack=1.
REQ-023 DATA read: release SDA, shift sdai sampled at Q2 into shift register MSB first; DACK master releases SDA (NACK, single byte).
REQ-024 STOP: Q0 sdaoe=1, SCL low; Q1 release SCL; Q2 SCL high; Q3 release SDA; then IDLE with done=1 for one cycle.
REQ-025 Clock stretching: at Q1 end, SHALL not advance to Q2 until scli=1; tick counter holds meanwhile (also in START, STOP).
REQ-026 Unstretched latency: accepted start to done = 80*CLK_DIV+1 cycles full transaction; 44*CLK_DIV+1 on address NACK.
REQ-027 start while busy=1 SHALL be ignored; start in done cycle SHALL be accepted (busy rises next cycle).
REQ-028 busy SHALL fall in the same cycle done is asserted; nack SHALL hold its value until the next accepted start.
REQ-029 rdata SHALL not change on write transactions or on NACKed reads.

Reset
REQ-030 resetn=0 at any clk edge, including mid-transaction, SHALL force IDLE, scloe=0, sdaoe=0, busy=0, done=0, nack=0, rdata=0x00, counters 0, next cycle.
REQ-031 SHALL not generate STOP after a mid-transaction reset; lines are simply released.

Verification
REQ-032 CLK_DIV=4, write addr=0x22 wdata=0xA5, slave ACKs both -> bus bits 0x44 then 0xA5, done at cycle 321, nack=0.
REQ-033 Read addr=0x3C, slave ACKs and drives 0x5A -> address byte 0x79, master NACK on DACK, rdata=0x5A, nack=0.
REQ-034 Write addr=0x10, no slave (sdai=1) -> nack=1, no DATA phase, done at cycle 177, STOP observed.
REQ-035 Slave holds scli=0 for 50 cycles on bit 3 of ADDR -> bit timing paused, done delayed by 50 cycles, data intact.
REQ-036 resetn=0 during DATA bit 4 -> next cycle scloe=0, sdaoe=0, busy=0; new start afterwards completes normally.
REQ-037 start pulsed during busy -> ignored, single transaction, one done pulse.
